// File: rtl/nios_pio_gpio.sv
// WIDTH-bit Avalon-MM GPIO slave: output register with atomic set/clear, synchronised
// inputs with per-bit edge capture (RW1C) and a maskable level interrupt.
module nios_pio_gpio #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'd1,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [WIDTH-1:0] RST_OUT   = RESET_VALUE[WIDTH-1:0];
  localparam logic [2:0]       PRIME_MAX = 3'(SYNC_STAGES + 1);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_INPUT  = 3'd1;
  localparam logic [2:0] A_EDGE   = 3'd2;
  localparam logic [2:0] A_MASK   = 3'd3;
  localparam logic [2:0] A_OUTSET = 3'd4;
  localparam logic [2:0] A_OUTCLR = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_prev;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_nxt;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_nxt;
  logic [2:0]       prime_cnt;
  logic             primed;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign in_sync   = sync_q[SYNC_STAGES-1];
  assign primed    = (prime_cnt == PRIME_MAX);
  assign out_port  = data_out;
  assign irq       = |(edge_cap & irq_mask);

  // Input synchroniser chain and previous-value register for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= {WIDTH{1'b0}};
      in_prev <= {WIDTH{1'b0}};
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      in_prev <= in_sync;
    end
  end

  // Saturating post-reset counter; edges are ignored until the chain has refilled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_cnt <= 3'd0;
    end else if (prime_cnt != PRIME_MAX) begin
      prime_cnt <= prime_cnt + 3'd1;
    end else begin
      prime_cnt <= prime_cnt;
    end
  end

  // Edge detector selected by EDGE_TYPE
  always_comb begin
    det = {WIDTH{1'b0}};
    case (EDGE_TYPE)
      1:       det = ~in_sync & in_prev;
      2:       det = in_sync ^ in_prev;
      default: det = in_sync & ~in_prev;
    endcase
  end

  // Edge capture next state: W1C applied first so a same-cycle detection wins
  always_comb begin
    edge_nxt = edge_cap;
    if (wr && (address == A_EDGE)) begin
      edge_nxt = edge_nxt & ~wd;
    end else begin
      edge_nxt = edge_nxt;
    end
    if (primed) begin
      edge_nxt = edge_nxt | det;
    end else begin
      edge_nxt = edge_nxt;
    end
  end

  // Output register next state: load, set or clear
  always_comb begin
    data_nxt = data_out;
    if (wr) begin
      case (address)
        A_DATA:   data_nxt = wd;
        A_OUTSET: data_nxt = data_out | wd;
        A_OUTCLR: data_nxt = data_out & ~wd;
        default:  data_nxt = data_out;
      endcase
    end else begin
      data_nxt = data_out;
    end
  end

  // Register file state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= RST_OUT;
      edge_cap <= {WIDTH{1'b0}};
      irq_mask <= {WIDTH{1'b0}};
    end else begin
      data_out <= data_nxt;
      edge_cap <= edge_nxt;
      if (wr && (address == A_MASK)) begin
        irq_mask <= wd;
      end else begin
        irq_mask <= irq_mask;
      end
    end
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    readdata = 32'd0;
    case (address)
      A_DATA:  readdata[WIDTH-1:0] = data_out;
      A_INPUT: readdata[WIDTH-1:0] = in_sync;
      A_EDGE:  readdata[WIDTH-1:0] = edge_cap;
      A_MASK:  readdata[WIDTH-1:0] = irq_mask;
      default: readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_nios_pio_gpio.sv
// Directed bench for nios_pio_gpio: an 8-bit rising-edge instance and a
// 32-bit any-edge instance share one clock.
module tb_nios_pio_gpio;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic        rst8 = 1'b1, cs8 = 1'b0, wn8 = 1'b1;
  logic [2:0]  addr8 = 3'd0;
  logic [31:0] wdat8 = 32'd0, rdat8;
  logic [7:0]  in8 = 8'h00, out8;
  logic        irq8;

  logic        rst32 = 1'b1, cs32 = 1'b0, wn32 = 1'b1;
  logic [2:0]  addr32 = 3'd0;
  logic [31:0] wdat32 = 32'd0, rdat32;
  logic [31:0] in32 = 32'd0, out32;
  logic        irq32;

  nios_pio_gpio #(.WIDTH(8), .RESET_VALUE(32'd1), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset(rst8), .address(addr8), .chipselect(cs8), .write_n(wn8),
    .writedata(wdat8), .readdata(rdat8), .in_port(in8), .out_port(out8), .irq(irq8));

  nios_pio_gpio #(.WIDTH(32), .RESET_VALUE(32'd1), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut32 (
    .clk(clk), .reset(rst32), .address(addr32), .chipselect(cs32), .write_n(wn32),
    .writedata(wdat32), .readdata(rdat32), .in_port(in32), .out_port(out32), .irq(irq32));

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr8(input logic [2:0] a, input logic [31:0] d, input logic sel);
    addr8 = a; wdat8 = d; cs8 = sel; wn8 = 1'b0;
    tick(1);
    cs8 = 1'b0; wn8 = 1'b1;
  endtask

  task automatic rd8(input logic [2:0] a, output logic [31:0] d);
    addr8 = a;
    #1;
    d = rdat8;
  endtask

  task automatic wr32(input logic [2:0] a, input logic [31:0] d);
    addr32 = a; wdat32 = d; cs32 = 1'b1; wn32 = 1'b0;
    tick(1);
    cs32 = 1'b0; wn32 = 1'b1;
  endtask

  task automatic rd32(input logic [2:0] a, output logic [31:0] d);
    addr32 = a;
    #1;
    d = rdat32;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    logic [31:0] exp;
    in8 = 8'hFF;
    tick(2);
    total++;
    if (out8 !== 8'h01) $display("FAIL reset_out_port got %h want 01", out8);
    else passed++;
    total++;
    if (irq8 !== 1'b0) $display("FAIL reset_irq got %b want 0", irq8);
    else passed++;
    for (int a = 0; a < 8; a++) begin
      rd8(3'(a), r);
      exp = (a == 0) ? 32'h1 : 32'h0;
      total++;
      if (r !== exp) $display("FAIL reset_read addr %0d got %h want %h", a, r, exp);
      else passed++;
    end
    rst8 = 1'b0;
    rst32 = 1'b0;
  endtask

  task automatic test_data;
    logic [31:0] r;
    wr8(3'd0, 32'hFFFF_FFA5, 1'b1);
    total++;
    if (out8 !== 8'hA5) $display("FAIL data_write got %h want a5", out8);
    else passed++;
    rd8(3'd0, r);
    total++;
    if (r !== 32'h0000_00A5) $display("FAIL data_read got %h want 000000a5", r);
    else passed++;
    wr8(3'd0, 32'h0000_003C, 1'b0);
    total++;
    if (out8 !== 8'hA5) $display("FAIL data_nocs got %h want a5", out8);
    else passed++;
  endtask

  task automatic test_setclr;
    logic [31:0] r;
    wr8(3'd4, 32'h0000_000A, 1'b1);
    total++;
    if (out8 !== 8'hAF) $display("FAIL outset got %h want af", out8);
    else passed++;
    wr8(3'd5, 32'h0000_0081, 1'b1);
    total++;
    if (out8 !== 8'h2E) $display("FAIL outclr got %h want 2e", out8);
    else passed++;
    for (int a = 4; a < 8; a++) begin
      rd8(3'(a), r);
      total++;
      if (r !== 32'h0) $display("FAIL read_hi addr %0d got %h want 0", a, r);
      else passed++;
    end
    wr8(3'd6, 32'h0000_00FF, 1'b1);
    total++;
    if (out8 !== 8'h2E) $display("FAIL addr6_write got %h want 2e", out8);
    else passed++;
  endtask

  task automatic test_edge;
    logic [31:0] r;
    rd8(3'd2, r);
    total++;
    if (r !== 32'h0) $display("FAIL prime_edge got %h want 0", r);
    else passed++;
    rd8(3'd1, r);
    total++;
    if (r !== 32'hFF) $display("FAIL input_ff got %h want ff", r);
    else passed++;
    in8 = 8'hF7;
    tick(4);
    rd8(3'd2, r);
    total++;
    if (r !== 32'h0) $display("FAIL falling_ignored got %h want 0", r);
    else passed++;
    in8 = 8'hFF;
    tick(1);
    rd8(3'd1, r);
    total++;
    if (r !== 32'hF7) $display("FAIL input_lat1 got %h want f7", r);
    else passed++;
    tick(1);
    rd8(3'd1, r);
    total++;
    if (r !== 32'hFF) $display("FAIL input_lat2 got %h want ff", r);
    else passed++;
    rd8(3'd2, r);
    total++;
    if (r !== 32'h0) $display("FAIL edge_lat2 got %h want 0", r);
    else passed++;
    tick(1);
    rd8(3'd2, r);
    total++;
    if (r !== 32'h08) $display("FAIL edge_lat3 got %h want 08", r);
    else passed++;
    total++;
    if (irq8 !== 1'b0) $display("FAIL irq_unmasked got %b want 0", irq8);
    else passed++;
  endtask

  task automatic test_irq;
    logic [31:0] r;
    wr8(3'd3, 32'h0000_0008, 1'b1);
    total++;
    if (irq8 !== 1'b1) $display("FAIL irq_mask_on got %b want 1", irq8);
    else passed++;
    rd8(3'd3, r);
    total++;
    if (r !== 32'h08) $display("FAIL mask_read got %h want 08", r);
    else passed++;
    wr8(3'd2, 32'h0000_0000, 1'b1);
    rd8(3'd2, r);
    total++;
    if (r !== 32'h08 || irq8 !== 1'b1) $display("FAIL w1c_zero got edge %h irq %b want 08 1", r, irq8);
    else passed++;
    wr8(3'd2, 32'h0000_0008, 1'b1);
    total++;
    if (irq8 !== 1'b0) $display("FAIL irq_clear got %b want 0", irq8);
    else passed++;
    rd8(3'd2, r);
    total++;
    if (r !== 32'h0) $display("FAIL edge_clear got %h want 0", r);
    else passed++;
  endtask

  task automatic test_collision;
    logic [31:0] r;
    in8 = 8'hFB;
    tick(4);
    in8 = 8'hFF;
    tick(2);
    wr8(3'd2, 32'h0000_0004, 1'b1);
    rd8(3'd2, r);
    total++;
    if (r !== 32'h04) $display("FAIL set_wins got %h want 04", r);
    else passed++;
    wr8(3'd2, 32'h0000_0004, 1'b1);
    rd8(3'd2, r);
    total++;
    if (r !== 32'h0) $display("FAIL clear_after got %h want 0", r);
    else passed++;
  endtask

  task automatic test_any_edge;
    logic [31:0] r;
    wr32(3'd0, 32'hFFFF_FFFF);
    total++;
    if (out32 !== 32'hFFFF_FFFF) $display("FAIL w32_data got %h want ffffffff", out32);
    else passed++;
    in32 = 32'h8000_0000;
    tick(3);
    rd32(3'd2, r);
    total++;
    if (r !== 32'h8000_0000) $display("FAIL any_rise got %h want 80000000", r);
    else passed++;
    wr32(3'd2, 32'h8000_0000);
    rd32(3'd2, r);
    total++;
    if (r !== 32'h0) $display("FAIL any_clear got %h want 0", r);
    else passed++;
    in32 = 32'h0000_0000;
    tick(3);
    rd32(3'd2, r);
    total++;
    if (r !== 32'h8000_0000) $display("FAIL any_fall got %h want 80000000", r);
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    wr32(3'd3, 32'h8000_0000);
    wr32(3'd0, 32'hDEAD_BEEF);
    total++;
    if (irq32 !== 1'b1) $display("FAIL pre_reset_irq got %b want 1", irq32);
    else passed++;
    in32 = 32'hFFFF_FFFF;
    #2;
    rst32 = 1'b1;
    #1;
    total++;
    if (out32 !== 32'h1 || irq32 !== 1'b0) $display("FAIL async_reset got out %h irq %b want 00000001 0", out32, irq32);
    else passed++;
    rd32(3'd2, r);
    total++;
    if (r !== 32'h0) $display("FAIL mid_reset_edge got %h want 0", r);
    else passed++;
    rd32(3'd3, r);
    total++;
    if (r !== 32'h0) $display("FAIL mid_reset_mask got %h want 0", r);
    else passed++;
    tick(2);
    rst32 = 1'b0;
    tick(6);
    rd32(3'd2, r);
    total++;
    if (r !== 32'h0) $display("FAIL reprime_edge got %h want 0", r);
    else passed++;
    rd32(3'd1, r);
    total++;
    if (r !== 32'hFFFF_FFFF) $display("FAIL reprime_input got %h want ffffffff", r);
    else passed++;
  endtask

  initial begin
    #1;
    test_reset();
    tick(6);
    test_data();
    test_setclr();
    test_edge();
    test_irq();
    test_collision();
    test_any_edge();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
